ps2_scancode_decoder: RTL and testbench
=======================================

Name: ps2_scancode_decoder

Overview:
Downstream consumer of the PS/2 receiver's scan_code/scan_ready strobe. It strips Set-2 prefix bytes (E0 extended, F0 break) and assembles complete key events with make/break and extended flags. It tracks shift state, translates a subset of keys to ASCII, and buffers events in a show-ahead FIFO with a valid/ready handshake for the application logic.

Parameters:
DEPTH, 4, event FIFO depth in entries; power of two, at least 2.
CW, $clog2(DEPTH)+1, width of fifo_count (derived, not overridden).

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
scan_code  input  8  byte from PS/2 receiver; valid only while scan_ready=1.
scan_ready  input  1  one-cycle strobe per received byte.
key_ready  input  1  consumer accepts the head event.
clr_overflow  input  1  one-cycle clear of the sticky overflow flag.
key_valid  output  1  FIFO non-empty; head event presented.
key_code  output  8  head event: final (non-prefix) scan code.
key_ext  output  1  head event: preceded by E0.
key_release  output  1  head event: preceded by F0 (break).
key_ascii  output  8  head event: ASCII value, 0x00 when not mappable.
key_ascii_valid  output  1  head event: key_ascii meaningful (make events only).
shift_held  output  1  live state: left or right shift currently down.
overflow  output  1  sticky: an event was dropped because the FIFO was full.
fifo_count  output  CW  number of events stored.

Behaviour:
- Reset is synchronous and active-high on clk. It empties the FIFO, sets the FSM to IDLE and clears shift_held and overflow. All outputs read 0 in the cycle after reset. Reset mid-sequence discards any pending prefix.
- A byte is consumed only in cycles with scan_ready=1. Each high cycle counts as one byte.
- FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0.
  - IDLE: E0 -> GOT_E0; F0 -> GOT_F0.
  - GOT_E0: F0 -> GOT_E0F0.
  - Any other code in any state emits an event and returns to IDLE. ext=1 in GOT_E0/GOT_E0F0; release=1 in GOT_F0/GOT_E0F0.
  - A repeated E0 in GOT_E0 stays in GOT_E0.
  - Control bytes 00, AA, E1, EE, FA, FC, FD, FE, FF are dropped in any state and force IDLE.
- Shift: non-extended 12 or 59 make sets the matching internal bit; their break clears it. shift_held is the OR of the two bits, updated at the same edge the event is pushed. Shift events are still pushed, with ascii_valid=0.
- ASCII, computed from shift state before the event's own update; make events only, release always gives ascii_valid=0 and ascii=00:
  - Letters: A–Z per Set-2, giving lowercase 0x61–0x7A, or uppercase 0x41–0x5A when shift held.
  - Digits 0–9: 0x30–0x39, shift ignored.
  - 29 -> 0x20; 5A -> 0x0D; 66 -> 0x08; 76 -> 0x1B.
  - Extended codes are unmapped, except E0 5A -> 0x0D.
  - Everything else: ascii_valid=0.
- Latency: the final byte accepted in cycle N is written at the end of cycle N. key_valid and the head fields are visible in cycle N+1 when the FIFO was empty.
- FIFO ordering and handshake:
  - Strict FIFO order.
  - Pop when key_valid && key_ready.
  - Head fields stay stable while key_valid=1 and key_ready=0.
  - key_ready while empty is ignored.
- Full and simultaneous events:
  - Push and pop in the same cycle: both occur and fifo_count is unchanged.
  - Full with no pop: the new event is dropped and overflow is set. Full with a same-cycle pop: the push is accepted.
  - overflow clears on clr_overflow or reset. A simultaneous clr_overflow and new drop leaves overflow=1.
- Pointers are log2(DEPTH) bits and wrap naturally. fifo_count never exceeds DEPTH.

Test Plan:
- Make/break 'a': strobes 1C, then F0, 1C with key_ready=1 -> event1 code=1C ext=0 rel=0 ascii=0x61 valid=1, one cycle after the 1C strobe; event2 rel=1 ascii_valid=0.
- Shifted letter: 12, 1C, F0 1C, F0 12 -> shift_held=1 after the first strobe; the 1C make gives ascii=0x41; shift_held=0 after the final 12; 4 events, in order.
- Extended release: E0, F0, 75 -> single event code=75 ext=1 rel=1 ascii_valid=0; E0 5A -> ascii=0x0D ext=1.
- Overflow/backpressure (DEPTH=4): key_ready=0, six makes 16,1E,26,25,2E,36 -> fifo_count=4, overflow=1, head stable at code=16 ascii=0x31. Then key_ready=1 -> pops 16,1E,26,25 in order, empty. clr_overflow -> overflow=0.
- Full with simultaneous push/pop: FIFO full, key_ready=1 on the same cycle as a 29 make -> count stays 4, overflow stays 0, 29 (ascii 0x20) is the last entry.
- Reset mid-sequence and junk: E0 F0, then reset, then 1C -> non-extended make 'a'. AA and FA alone -> no events. E0 FA 1C -> ext=0 make.

Source files
------------

// File: rtl/ps2_scancode_decoder_if.sv
// Bundles the scan-code input strobe, the key-event output stream and
// the live status signals of the PS/2 scan-code decoder.
//
// Handshake: scan_ready is a one-cycle strobe. Each high cycle delivers one
// byte on scan_code, and there is no back-pressure on that side. On the event
// side, key_valid=1 presents the head event. The event transfers on any
// rising clk edge where key_valid && key_ready. While key_valid=1 and
// key_ready=0, every head field holds steady. key_ready while key_valid=0
// has no effect.
interface ps2_scancode_decoder_if #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
);
    logic [7:0]    scan_code;
    logic          scan_ready;
    logic          key_ready;
    logic          clr_overflow;
    logic          key_valid;
    logic [7:0]    key_code;
    logic          key_ext;
    logic          key_release;
    logic [7:0]    key_ascii;
    logic          key_ascii_valid;
    logic          shift_held;
    logic          overflow;
    logic [CW-1:0] fifo_count;
    logic [1:0]    fsm_state;   // prefix FSM state, exposed for observation

    modport master (
        output scan_code, scan_ready, key_ready, clr_overflow,
        input  key_valid, key_code, key_ext, key_release, key_ascii,
               key_ascii_valid, shift_held, overflow, fifo_count, fsm_state
    );

    modport slave (
        input  scan_code, scan_ready, key_ready, clr_overflow,
        output key_valid, key_code, key_ext, key_release, key_ascii,
               key_ascii_valid, shift_held, overflow, fifo_count, fsm_state
    );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan-code decoder: strips E0/F0 prefixes, tracks shift state,
// maps a subset of keys to ASCII and queues key events in a show-ahead FIFO.
module ps2_scancode_decoder #(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input logic                   clk,
    input logic                   reset,
    ps2_scancode_decoder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] GOT_E0   = 2'd1;
    localparam logic [1:0] GOT_F0   = 2'd2;
    localparam logic [1:0] GOT_E0F0 = 2'd3;

    // FIFO entry layout: {code[7:0], ext, release, ascii[7:0], ascii_valid}
    localparam int EW = 19;

    logic [1:0]    state, state_next;
    logic          is_ctrl;
    logic          ev_fire, ev_ext, ev_rel;
    logic [7:0]    asc;
    logic          asc_v;
    logic          lshift, rshift;
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty, push, pop, drop;

    // Bytes that abort any prefix sequence and are never reported as keys.
    always_comb begin
        is_ctrl = 1'b0;
        case (bus.scan_code)
            8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA,
            8'hFC, 8'hFD, 8'hFE, 8'hFF: is_ctrl = 1'b1;
            default:                    is_ctrl = 1'b0;
        endcase
    end

    // Prefix FSM: decides whether this byte advances a prefix or completes an event.
    always_comb begin
        state_next = state;
        ev_fire    = 1'b0;
        ev_ext     = (state == GOT_E0) || (state == GOT_E0F0);
        ev_rel     = (state == GOT_F0) || (state == GOT_E0F0);
        if (bus.scan_ready) begin
            if (is_ctrl) begin
                state_next = IDLE;
            end else if (bus.scan_code == 8'hE0 && (state == IDLE || state == GOT_E0)) begin
                state_next = GOT_E0;
            end else if (bus.scan_code == 8'hF0 && state == IDLE) begin
                state_next = GOT_F0;
            end else if (bus.scan_code == 8'hF0 && state == GOT_E0) begin
                state_next = GOT_E0F0;
            end else begin
                state_next = IDLE;
                ev_fire    = 1'b1;
            end
        end
    end

    // ASCII translation for make events, using shift state before this event.
    always_comb begin
        asc   = 8'h00;
        asc_v = 1'b0;
        if (!ev_rel && !ev_ext) begin
            asc_v = 1'b1;
            case (bus.scan_code)
                8'h1C: asc = 8'h61;  8'h32: asc = 8'h62;  8'h21: asc = 8'h63;
                8'h23: asc = 8'h64;  8'h24: asc = 8'h65;  8'h2B: asc = 8'h66;
                8'h34: asc = 8'h67;  8'h33: asc = 8'h68;  8'h43: asc = 8'h69;
                8'h3B: asc = 8'h6A;  8'h42: asc = 8'h6B;  8'h4B: asc = 8'h6C;
                8'h3A: asc = 8'h6D;  8'h31: asc = 8'h6E;  8'h44: asc = 8'h6F;
                8'h4D: asc = 8'h70;  8'h15: asc = 8'h71;  8'h2D: asc = 8'h72;
                8'h1B: asc = 8'h73;  8'h2C: asc = 8'h74;  8'h3C: asc = 8'h75;
                8'h2A: asc = 8'h76;  8'h1D: asc = 8'h77;  8'h22: asc = 8'h78;
                8'h35: asc = 8'h79;  8'h1A: asc = 8'h7A;
                8'h45: asc = 8'h30;  8'h16: asc = 8'h31;  8'h1E: asc = 8'h32;
                8'h26: asc = 8'h33;  8'h25: asc = 8'h34;  8'h2E: asc = 8'h35;
                8'h36: asc = 8'h36;  8'h3D: asc = 8'h37;  8'h3E: asc = 8'h38;
                8'h46: asc = 8'h39;
                8'h29: asc = 8'h20;  8'h5A: asc = 8'h0D;  8'h66: asc = 8'h08;
                8'h76: asc = 8'h1B;
                default: asc_v = 1'b0;
            endcase
            // Lowercase letters occupy 0x61-0x7A; shift moves them down by 0x20.
            if (asc_v && asc >= 8'h61 && (lshift || rshift))
                asc = asc - 8'h20;
        end else if (!ev_rel && ev_ext && bus.scan_code == 8'h5A) begin
            asc   = 8'h0D;
            asc_v = 1'b1;
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign pop   = !empty && bus.key_ready;
    assign push  = ev_fire && (!full || pop);
    assign drop  = ev_fire && full && !pop;

    // Prefix state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Shift tracking from non-extended left (12) and right (59) shift events.
    always_ff @(posedge clk) begin
        if (reset) begin
            lshift <= 1'b0;
            rshift <= 1'b0;
        end else if (ev_fire && !ev_ext) begin
            if (bus.scan_code == 8'h12) lshift <= !ev_rel;
            if (bus.scan_code == 8'h59) rshift <= !ev_rel;
        end
    end

    // Event storage; entries need no reset since the head is gated by key_valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.scan_code, ev_ext, ev_rel, asc, asc_v};
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            bus.overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (drop)                  bus.overflow <= 1'b1;
            else if (bus.clr_overflow) bus.overflow <= 1'b0;
        end
    end

    // Head presentation; all head fields read zero while the FIFO is empty.
    always_comb begin
        {bus.key_code, bus.key_ext, bus.key_release, bus.key_ascii, bus.key_ascii_valid} =
            empty ? '0 : mem[rd_ptr];
    end

    assign bus.key_valid  = !empty;
    assign bus.shift_held = lshift || rshift;
    assign bus.fifo_count = count;
    assign bus.fsm_state  = state;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench for ps2_scancode_decoder: directed scenarios followed by
// randomized byte streams, all checked against a prefix/queue reference model.
module tb_ps2_scancode_decoder;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    ps2_scancode_decoder_if #(.DEPTH(DEPTH)) bus ();

    ps2_scancode_decoder #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Event = {code[7:0], ext, release, ascii[7:0], ascii_valid}
    logic [18:0] exp_q[$];
    logic        pend_ext, pend_rel;
    logic        m_lshift, m_rshift;
    logic        m_ovf;

    logic [7:0] letter_tab [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                    8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                    8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_tab [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                   8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] pool [24] = '{8'h1C, 8'h1A, 8'h35, 8'h45, 8'h46, 8'h16, 8'h12, 8'h59,
                              8'h12, 8'h59, 8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'hF0, 8'h5A,
                              8'h29, 8'h66, 8'h76, 8'h75, 8'hAA, 8'hFA, 8'h00, 8'h0D};

    function automatic logic is_ctrl_byte(input logic [7:0] c);
        return c inside {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
    endfunction

    // Returns {ascii_valid, ascii}.
    function automatic logic [8:0] ascii_of(input logic [7:0] c, input logic ext,
                                            input logic rel, input logic sh);
        if (rel) return 9'h000;
        if (ext) return (c == 8'h5A) ? {1'b1, 8'h0D} : 9'h000;
        for (int i = 0; i < 26; i++)
            if (letter_tab[i] == c) return {1'b1, (sh ? 8'h41 : 8'h61) + 8'(i)};
        for (int i = 0; i < 10; i++)
            if (digit_tab[i] == c) return {1'b1, 8'h30 + 8'(i)};
        case (c)
            8'h29:   return {1'b1, 8'h20};
            8'h5A:   return {1'b1, 8'h0D};
            8'h66:   return {1'b1, 8'h08};
            8'h76:   return {1'b1, 8'h1B};
            default: return 9'h000;
        endcase
    endfunction

    task automatic model_reset();
        exp_q.delete();
        pend_ext = 1'b0;
        pend_rel = 1'b0;
        m_lshift = 1'b0;
        m_rshift = 1'b0;
        m_ovf    = 1'b0;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [18:0] head();
        return {bus.key_code, bus.key_ext, bus.key_release, bus.key_ascii, bus.key_ascii_valid};
    endfunction

    // Compare DUT against model, then apply one cycle of inputs to both.
    task automatic cycle(input logic [7:0] code, input logic sr, input logic kr, input logic clr);
        logic       pop, ev, ext, rel;
        logic [8:0] a;
        bus.scan_code    = code;
        bus.scan_ready   = sr;
        bus.key_ready    = kr;
        bus.clr_overflow = clr;
        check("key_valid", 32'(bus.key_valid), 32'(exp_q.size() > 0));
        check("fifo_count", 32'(bus.fifo_count), 32'(exp_q.size()));
        check("overflow", 32'(bus.overflow), 32'(m_ovf));
        check("shift_held", 32'(bus.shift_held), 32'(m_lshift | m_rshift));
        if (exp_q.size() > 0) check("head", 32'(head()), 32'(exp_q[0]));
        pop = (exp_q.size() > 0) && kr;
        ev  = 1'b0;
        ext = pend_ext;
        rel = pend_rel;
        if (sr) begin
            if (is_ctrl_byte(code)) begin
                pend_ext = 1'b0; pend_rel = 1'b0;
            end else if (code == 8'hE0 && !pend_rel) begin
                pend_ext = 1'b1;
            end else if (code == 8'hF0 && !pend_rel) begin
                pend_rel = 1'b1;
            end else begin
                ev = 1'b1;
                pend_ext = 1'b0; pend_rel = 1'b0;
            end
        end
        a = ascii_of(code, ext, rel, m_lshift | m_rshift);
        if (pop) void'(exp_q.pop_front());
        if (clr) m_ovf = 1'b0;
        if (ev) begin
            if (exp_q.size() < DEPTH) exp_q.push_back({code, ext, rel, a[7:0], a[8]});
            else                      m_ovf = 1'b1;
            if (!ext && code == 8'h12) m_lshift = !rel;
            if (!ext && code == 8'h59) m_rshift = !rel;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] code, input logic kr);
        cycle(code, 1'b1, kr, 1'b0);
    endtask

    task automatic idle(input int n, input logic kr);
        for (int i = 0; i < n; i++) cycle(8'h00, 1'b0, kr, 1'b0);
    endtask

    task automatic do_reset();
        bus.scan_ready   = 1'b0;
        bus.key_ready    = 1'b0;
        bus.clr_overflow = 1'b0;
        bus.scan_code    = 8'h00;
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        do_reset();

        // Reset state: every output reads zero.
        check("rst_key_valid", 32'(bus.key_valid), 0);
        check("rst_head", 32'(head()), 0);
        check("rst_flags", 32'({bus.shift_held, bus.overflow}), 0);
        check("rst_count", 32'(bus.fifo_count), 0);

        // Make/break 'a' with the consumer always ready.
        send(8'h1C, 1'b1);
        check("a_make_head", 32'(head()), 32'({8'h1C, 1'b0, 1'b0, 8'h61, 1'b1}));
        send(8'hF0, 1'b1);
        send(8'h1C, 1'b1);
        check("a_break_head", 32'(head()), 32'({8'h1C, 1'b0, 1'b1, 8'h00, 1'b0}));
        idle(2, 1'b1);

        // Shifted letter, events held until drained.
        send(8'h12, 1'b0);
        check("shift_after_12", 32'(bus.shift_held), 1);
        send(8'h1C, 1'b0);
        send(8'hF0, 1'b0); send(8'h1C, 1'b0);
        send(8'hF0, 1'b0); send(8'h12, 1'b0);
        check("shift_after_brk", 32'(bus.shift_held), 0);
        check("shift_count", 32'(bus.fifo_count), 4);
        cycle(8'h00, 1'b0, 1'b1, 1'b0);
        check("shift_A_head", 32'(head()), 32'({8'h1C, 1'b0, 1'b0, 8'h41, 1'b1}));
        idle(4, 1'b1);

        // Extended release and extended Enter.
        send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h75, 1'b0);
        check("ext_rel_head", 32'(head()), 32'({8'h75, 1'b1, 1'b1, 8'h00, 1'b0}));
        check("ext_rel_count", 32'(bus.fifo_count), 1);
        send(8'hE0, 1'b1); send(8'h5A, 1'b1);
        check("ext_enter_head", 32'(head()), 32'({8'h5A, 1'b1, 1'b0, 8'h0D, 1'b1}));
        idle(2, 1'b1);

        // Overflow under back-pressure.
        send(8'h16, 1'b0); send(8'h1E, 1'b0); send(8'h26, 1'b0);
        send(8'h25, 1'b0); send(8'h2E, 1'b0); send(8'h36, 1'b0);
        check("ovf_count", 32'(bus.fifo_count), 4);
        check("ovf_flag", 32'(bus.overflow), 1);
        idle(2, 1'b0);
        check("ovf_head_stable", 32'(head()), 32'({8'h16, 1'b0, 1'b0, 8'h31, 1'b1}));
        cycle(8'h00, 1'b0, 1'b1, 1'b0);
        check("ovf_pop2", 32'(bus.key_code), 32'h1E);
        cycle(8'h00, 1'b0, 1'b1, 1'b0);
        check("ovf_pop3", 32'(bus.key_code), 32'h26);
        cycle(8'h00, 1'b0, 1'b1, 1'b0);
        check("ovf_pop4", 32'(bus.key_code), 32'h25);
        cycle(8'h00, 1'b0, 1'b1, 1'b0);
        check("ovf_empty", 32'(bus.key_valid), 0);
        cycle(8'h00, 1'b0, 1'b0, 1'b1);
        check("ovf_cleared", 32'(bus.overflow), 0);

        // Full FIFO with a push and pop in the same cycle.
        send(8'h16, 1'b0); send(8'h1E, 1'b0); send(8'h26, 1'b0); send(8'h25, 1'b0);
        send(8'h29, 1'b1);
        check("pp_count", 32'(bus.fifo_count), 4);
        check("pp_ovf", 32'(bus.overflow), 0);
        idle(3, 1'b1);
        check("pp_last", 32'(head()), 32'({8'h29, 1'b0, 1'b0, 8'h20, 1'b1}));
        idle(1, 1'b1);

        // Reset in the middle of a prefix sequence.
        send(8'hE0, 1'b0); send(8'hF0, 1'b0);
        do_reset();
        send(8'h1C, 1'b0);
        check("rst_mid_head", 32'(head()), 32'({8'h1C, 1'b0, 1'b0, 8'h61, 1'b1}));
        idle(1, 1'b1);

        // Control bytes produce nothing and abort prefixes.
        send(8'hAA, 1'b0); send(8'hFA, 1'b0);
        check("junk_none", 32'(bus.key_valid), 0);
        send(8'hE0, 1'b0); send(8'hFA, 1'b0); send(8'h1C, 1'b0);
        check("junk_abort", 32'(head()), 32'({8'h1C, 1'b0, 1'b0, 8'h61, 1'b1}));
        idle(1, 1'b1);

        // Randomized byte streams with random back-pressure and clears.
        for (int i = 0; i < 600; i++) begin
            logic [7:0] b;
            b = ($urandom_range(0, 9) < 8) ? pool[$urandom_range(0, 23)] : 8'($urandom());
            cycle(b, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 19) == 0));
        end
        idle(DEPTH + 1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
